// File: rtl/ee371_pkg.sv
// Shared definitions for the input conditioning path: debounce state
// encoding and an elaboration-time ceil(log2) helper.
package ee371_pkg;

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    PEND_HI   = 2'd1,
    STABLE_HI = 2'd2,
    PEND_LO   = 2'd3
  } db_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced input: two-flop synchronizer, four-state qualification FSM
// with a stability counter, and registered edge pulses.
module debounce_channel
  import ee371_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  localparam int CNT_W = clog2(STABLE_CYCLES) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             s1;
  logic             s2;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      state <= STABLE_LO;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      s1   <= raw;
      s2   <= s1;
      rise <= 1'b0;
      fall <= 1'b0;
      // The sample that opens a pending state already counts as the first.
      case (state)
        STABLE_LO: begin
          if (s2) begin
            state <= PEND_HI;
            cnt   <= CNT_ONE;
          end
        end
        PEND_HI: begin
          if (!s2) begin
            state <= STABLE_LO;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_HI;
            level <= 1'b1;
            rise  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        STABLE_HI: begin
          if (!s2) begin
            state <= PEND_LO;
            cnt   <= CNT_ONE;
          end
        end
        PEND_LO: begin
          if (s2) begin
            state <= STABLE_HI;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state <= STABLE_LO;
            level <= 1'b0;
            fall  <= 1'b1;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= STABLE_LO;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/input_conditioner.sv
// Bank of independent debounced switch/key inputs feeding Main's input bus:
// clean levels plus single-cycle rise/fall pulses per channel.
module input_conditioner #(
  parameter int WIDTH         = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw_in,
  output logic [WIDTH-1:0] level_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    debounce_channel #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .rst  (rst),
      .raw  (raw_in[i]),
      .level(level_out[i]),
      .rise (rise_pulse[i]),
      .fall (fall_pulse[i])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios with literal expectations
// plus randomized toggling checked every cycle against a sample-window model.
module tb_input_conditioner;

  localparam int W  = 4;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] raw_in = '0;
  logic [W-1:0] level_out, rise_pulse, fall_pulse;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 1'b0;

  input_conditioner #(.WIDTH(W), .STABLE_CYCLES(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .level_out (level_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a level flips once the last SC synchronized samples all disagree with it.
  logic [W-1:0] m_s1 = '0, m_s2 = '0;
  logic [W-1:0] exp_level = '0, exp_rise = '0, exp_fall = '0;
  bit           win[W][$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_s1 = '0; m_s2 = '0;
      exp_level = '0; exp_rise = '0; exp_fall = '0;
      for (int c = 0; c < W; c++) win[c].delete();
    end else begin
      exp_rise = '0;
      exp_fall = '0;
      for (int c = 0; c < W; c++) begin
        bit differ;
        win[c].push_back(m_s2[c]);
        if (win[c].size() > SC) void'(win[c].pop_front());
        if (win[c].size() == SC) begin
          differ = 1'b1;
          foreach (win[c][j]) if (win[c][j] == exp_level[c]) differ = 1'b0;
          if (differ) begin
            exp_level[c] = ~exp_level[c];
            if (exp_level[c]) exp_rise[c] = 1'b1;
            else exp_fall[c] = 1'b1;
          end
        end
      end
      m_s2 = m_s1;
      m_s1 = raw_in;
    end
  end

  initial forever begin
    @(negedge clk);
    if (cmp_on) begin
      check("model_level", level_out, exp_level);
      check("model_rise", rise_pulse, exp_rise);
      check("model_fall", fall_pulse, exp_fall);
    end
  end

  task automatic do_reset();
    @(negedge clk);
    #2;
    raw_in = '0;
    rst = 1'b1;
    #1;
    check("rst_level", level_out, '0);
    check("rst_rise", rise_pulse, '0);
    check("rst_fall", fall_pulse, '0);
    cmp_on = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
  endtask

  initial begin
    bit seq [7];
    int hold [W];

    do_reset();

    // Clean press on channel 0
    @(negedge clk); #1 raw_in = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("press_level", level_out, (k >= 5) ? 4'b0001 : 4'b0000);
      check("press_rise", rise_pulse, (k == 5) ? 4'b0001 : 4'b0000);
      check("press_fall", fall_pulse, 4'b0000);
      check("press_model", exp_level, (k >= 5) ? 4'b0001 : 4'b0000);
    end

    // Three-cycle glitch on channel 1
    do_reset();
    @(negedge clk); #1 raw_in = 4'b0010;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      check("glitch_level", level_out, 4'b0000);
      check("glitch_pulses", rise_pulse | fall_pulse, 4'b0000);
      if (k == 2) raw_in = 4'b0000;
    end

    // Bounce 1,1,0,1,1,1,1 on channel 2
    do_reset();
    seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk); #1 raw_in[2] = seq[0];
    for (int k = 0; k < 13; k++) begin
      @(posedge clk); #1;
      check("bounce_rise", rise_pulse, (k == 8) ? 4'b0100 : 4'b0000);
      check("bounce_level", level_out, (k >= 8) ? 4'b0100 : 4'b0000);
      raw_in[2] = (k + 1 < 7) ? seq[k+1] : 1'b1;
    end

    // All channels together, up then down
    do_reset();
    @(negedge clk); #1 raw_in = 4'b1111;
    for (int k = 0; k < 18; k++) begin
      @(posedge clk); #1;
      check("all_rise", rise_pulse, (k == 5) ? 4'b1111 : 4'b0000);
      check("all_fall", fall_pulse, (k == 15) ? 4'b1111 : 4'b0000);
      check("all_level", level_out, (k >= 5 && k < 15) ? 4'b1111 : 4'b0000);
      if (k == 9) raw_in = 4'b0000;
    end

    // Reset while channel 3 is pending
    do_reset();
    @(negedge clk); #1 raw_in = 4'b1000;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("pend_rise", rise_pulse, 4'b0000);
      if (k == 3) begin
        rst = 1'b1;
        #1 check("pend_rst_level", level_out, 4'b0000);
      end
    end
    repeat (2) begin
      @(posedge clk); #1;
      check("pend_hold_rise", rise_pulse, 4'b0000);
    end
    @(negedge clk); #1 rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      check("pend_after_rise", rise_pulse, (k == 5) ? 4'b1000 : 4'b0000);
      check("pend_after_level", level_out, (k >= 5) ? 4'b1000 : 4'b0000);
    end

    // Randomized hold times straddling the qualification length
    do_reset();
    for (int c = 0; c < W; c++) hold[c] = $urandom_range(1, 9);
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); #1;
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          raw_in[c] = ~raw_in[c];
          hold[c] = $urandom_range(1, 9);
        end else begin
          hold[c]--;
        end
      end
      if ($urandom_range(0, 249) == 0) begin
        #2 rst = 1'b1;
        #1 check("rand_rst_level", level_out, '0);
        @(posedge clk);
        @(negedge clk); #1 rst = 1'b0;
      end
    end

    repeat (2) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Multi-channel synchronizer, debouncer and edge-pulse generator for raw switch/button inputs. Sits directly upstream of `Main`: board switches and keys enter here, and the clean levels and single-cycle edge pulses drive `Main`'s input bus in place of the bench `Tester`. Each channel is independent, with a 2-flop synchronizer and a 4-state debounce FSM with a stability counter.

## Interface
Parameters:
- `WIDTH`, 4, number of independent input channels.
- `STABLE_CYCLES`, 4, consecutive synchronized samples required to accept a level change; legal range 2..65535.
- `CNT_W`, `$clog2(STABLE_CYCLES)+1`, counter width; derived, never overridden.

Ports:
- `clk`  in  1  system clock; all state on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `raw_in`  in  WIDTH  asynchronous raw inputs.
- `level_out`  out  WIDTH  debounced level per channel.
- `rise_pulse`  out  WIDTH  one-cycle pulse when `level_out[i]` goes 0→1.
- `fall_pulse`  out  WIDTH  one-cycle pulse when `level_out[i]` goes 1→0.

## Operation
- Reset (async assert, any time): sync flops `s1`/`s2`=0, `state`=STABLE_LO, `cnt`=0, `level_out`=0, `rise_pulse`=0, `fall_pulse`=0.
- Synchronizer: `s1 <= raw_in[i]`, `s2 <= s1`. The FSM uses only `s2`.
- FSM states, per channel: STABLE_LO, PEND_HI, STABLE_HI, PEND_LO.
  - STABLE_LO: if `s2`=1, go to PEND_HI with `cnt`=1; else stay.
  - PEND_HI: if `s2`=0, go to STABLE_LO with `cnt`=0 and no pulse. If `s2`=1 and `cnt`==STABLE_CYCLES-1, go to STABLE_HI with `level_out`=1, `rise_pulse`=1, `cnt`=0. Otherwise `cnt`++.
  - STABLE_HI and PEND_LO mirror the above with polarity inverted and `fall_pulse`.
- Pulses are registered and high for exactly one cycle, coincident with the first cycle of the new `level_out`.
- `rise_pulse[i]` and `fall_pulse[i]` are never high together. Different channels may pulse in the same cycle.
- `cnt` never exceeds STABLE_CYCLES-1, so no wrap-around is possible.
- If `raw_in` is high while `rst` is asserted, it is treated as a fresh 0→1 change after release. It produces `rise_pulse` with normal latency.
- A reset during PEND_* aborts the change. No pulse is emitted, and the level returns to 0.

## Timing
- Let E0 be the first rising edge at which a new `raw_in[i]` value is sampled into `s1`.
  - `s2` takes the new value at E1.
  - The FSM enters PEND at E2.
  - `level_out` and the pulse update at E(STABLE_CYCLES+1).
  - Latency is therefore STABLE_CYCLES+2 edges; with defaults, `level_out` changes at E5.
- The accepted value must be present on `s2` for STABLE_CYCLES consecutive edges. A single deviating sample restarts qualification.
- The minimum accepted pulse width on `raw_in` is STABLE_CYCLES cycles. Glitches of STABLE_CYCLES-1 cycles or less never reach `level_out`.
- Throughput: a reversed change can begin qualifying on the edge immediately after acceptance.
- All outputs are driven directly from flops. There is no combinational path from `raw_in` to any output.

## Structure
- Shared package/include `ee371_pkg`:
  - 2-bit state encoding localparams: STABLE_LO=0, PEND_HI=1, STABLE_HI=2, PEND_LO=3.
  - clog2 helper.
- Sub-module `debounce_channel` (ports `clk`, `rst`, `raw`, `level`, `rise`, `fall`; parameter `STABLE_CYCLES`) holds the synchronizer, FSM and counter.
- `input_conditioner` instantiates `debounce_channel` WIDTH times in a generate loop.

## Test plan
Bench uses WIDTH=4, STABLE_CYCLES=4.
- Reset: drive `raw_in`=4'b0000, assert `rst` mid-cycle -> all outputs 0 immediately, before the next `clk` edge.
- Clean press: `raw_in[0]` 0→1 held sampled from E0 -> `level_out`=4'b0001 from E5; `rise_pulse`=4'b0001 for the E5 cycle only; `fall_pulse` stays 0.
- Glitch: `raw_in[1]` high for 3 cycles then low -> `level_out[1]`, `rise_pulse[1]` and `fall_pulse[1]` stay 0 throughout.
- Bounce restart: `raw_in[2]` sequence 1,1,0,1,1,1,1 -> single `rise_pulse[2]` 4 edges after the final 1-run reaches `s2`, never earlier.
- Simultaneous channels: `raw_in` 4'b0000→4'b1111 at E0, then 4'b1111→4'b0000 at E10 -> `rise_pulse`=4'b1111 at E5, `fall_pulse`=4'b1111 at E15, each for one cycle.
- Reset mid-pend: `raw_in[3]`=1, assert `rst` at E3 -> no `rise_pulse[3]`; after release with `raw_in[3]` still 1, `rise_pulse[3]` occurs 6 edges after the first post-release sampling edge.
